// File: rtl/store_rs.sv
// Store reservation station: captures base/data operands (value or ROB tag),
// snoops the CDB until both are ready, then writes the data cache and reports to the ROB.
module store_rs #(
    parameter int                  WORD_SIZE = 32,
    parameter int                  RB_SIZE   = 8,
    parameter int                  RB_INDEX  = 4,
    parameter logic [RB_INDEX-1:0] READY     = 4'd15,
    parameter logic [RB_INDEX-1:0] NULL      = 4'd14,
    parameter int                  FU_INDEX  = 3,
    parameter int                  FU_NUM    = 8,
    parameter int                  FUINDEX   = 1,
    parameter int                  REG_INDEX = 5,
    parameter int                  RS_START  = 25,
    parameter int                  RT_START  = 20,
    parameter int                  IMM_START = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [FU_NUM-1:0]             flush_bus,
    input  logic [FU_INDEX-1:0]           fu,
    input  logic [RB_INDEX-1:0]           RB_index,
    input  logic [WORD_SIZE-1:0]          inst,
    output logic [REG_INDEX-1:0]          reg_numj,
    output logic [REG_INDEX-1:0]          reg_numk,
    input  logic [WORD_SIZE-1:0]          vj,
    input  logic [WORD_SIZE-1:0]          vk,
    input  logic [RB_INDEX-1:0]           qj,
    input  logic [RB_INDEX-1:0]           qk,
    input  logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data,
    input  logic [RB_SIZE-1:0]            CDB_data_valid,
    output logic [FU_NUM-1:0]             busy_out,
    output logic [FU_NUM*WORD_SIZE-1:0]   data_bus,
    output logic [FU_NUM-1:0]             valid_bus,
    output logic [FU_NUM*RB_INDEX-1:0]    RB_index_bus,
    output logic [WORD_SIZE-1:0]          c_ptr,
    output logic [WORD_SIZE-1:0]          c_wdata,
    output logic                          c_write_enable,
    input  logic                          c_ack
);

    typedef enum logic [1:0] {IDLE, WAIT_OPS, WRITE, DONE} state_t;

    state_t               state_q;
    logic                 busy_q, valid_q, cwe_q, flush_pend_q;
    logic [RB_INDEX-1:0]  dest_q, qj_q, qk_q, qj_d, qk_d;
    logic [WORD_SIZE-1:0] vj_q, vk_q, vj_d, vk_d, off_q, result_q, c_ptr_q, c_wdata_q;
    logic [WORD_SIZE-1:0] off_d;

    logic flush, dispatch, unused_ok;
    assign flush     = flush_bus[FUINDEX];
    assign dispatch  = (fu == FU_INDEX'(FUINDEX));
    assign unused_ok = ^{inst[WORD_SIZE-1:RS_START+1], flush_bus};
    assign off_d     = {{(WORD_SIZE-16){inst[IMM_START]}}, inst[IMM_START-:16]};

    assign reg_numj = (state_q == IDLE) ? inst[RS_START-:REG_INDEX] : '0;
    assign reg_numk = (state_q == IDLE) ? inst[RT_START-:REG_INDEX] : '0;

    // Operand resolution: at issue the sources are the register-file lookups, afterwards the held tags.
    always_comb begin
        logic [RB_INDEX-1:0]  tj, tk;
        logic [WORD_SIZE-1:0] sj, sk;
        tj   = (state_q == IDLE) ? qj : qj_q;
        tk   = (state_q == IDLE) ? qk : qk_q;
        vj_d = (state_q == IDLE) ? vj : vj_q;
        vk_d = (state_q == IDLE) ? vk : vk_q;
        qj_d = tj;
        qk_d = tk;
        for (int i = 0; i < RB_SIZE; i++) begin
            sj = CDB_data_data[i*WORD_SIZE +: WORD_SIZE];
            sk = CDB_data_data[i*WORD_SIZE +: WORD_SIZE];
            if (tj == RB_INDEX'(i) && CDB_data_valid[i]) begin
                vj_d = sj;
                qj_d = READY;
            end
            if (tk == RB_INDEX'(i) && CDB_data_valid[i]) begin
                vk_d = sk;
                qk_d = READY;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            dest_q       <= NULL;
            result_q     <= '0;
            cwe_q        <= 1'b0;
            c_ptr_q      <= '0;
            c_wdata_q    <= '0;
            flush_pend_q <= 1'b0;
            qj_q         <= READY;
            qk_q         <= READY;
            vj_q         <= '0;
            vk_q         <= '0;
            off_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        dest_q  <= NULL;
                    end else if (dispatch) begin
                        busy_q  <= 1'b1;
                        dest_q  <= RB_index;
                        off_q   <= off_d;
                        qj_q    <= qj_d;
                        qk_q    <= qk_d;
                        vj_q    <= vj_d;
                        vk_q    <= vk_d;
                        state_q <= WAIT_OPS;
                    end
                end
                WAIT_OPS: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        dest_q  <= NULL;
                        state_q <= IDLE;
                    end else begin
                        qj_q <= qj_d;
                        qk_q <= qk_d;
                        vj_q <= vj_d;
                        vk_q <= vk_d;
                        if (qj_q == READY && qk_q == READY) begin
                            c_ptr_q   <= vj_q + off_q;
                            c_wdata_q <= vk_q;
                            cwe_q     <= 1'b1;
                            state_q   <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    // A flush cannot abort the cache write; it only suppresses the ROB report.
                    if (c_ack) begin
                        cwe_q        <= 1'b0;
                        result_q     <= vk_q;
                        flush_pend_q <= 1'b0;
                        if (flush_pend_q || flush) begin
                            busy_q  <= 1'b0;
                            dest_q  <= NULL;
                            state_q <= IDLE;
                        end else begin
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end
                    end else if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    dest_q  <= NULL;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign c_ptr          = c_ptr_q;
    assign c_wdata        = c_wdata_q;
    assign c_write_enable = cwe_q;

    for (genvar g = 0; g < FU_NUM; g++) begin : g_bus
        if (g == FUINDEX) begin : g_own
            assign busy_out[g]                                = busy_q;
            assign valid_bus[g]                               = valid_q;
            assign data_bus[g*WORD_SIZE +: WORD_SIZE]         = result_q;
            assign RB_index_bus[g*RB_INDEX +: RB_INDEX]       = dest_q;
        end else begin : g_other
            assign busy_out[g]                                = 1'bz;
            assign valid_bus[g]                               = 1'bz;
            assign data_bus[g*WORD_SIZE +: WORD_SIZE]         = {WORD_SIZE{1'bz}};
            assign RB_index_bus[g*RB_INDEX +: RB_INDEX]       = {RB_INDEX{1'bz}};
        end
    end

endmodule

// File: tb/tb_store_rs.sv
// Directed bench for store_rs: issue, CDB snooping, cache handshake, flush and reset.
module tb_store_rs;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   flush_bus;
    logic [2:0]   fu;
    logic [3:0]   RB_index;
    logic [31:0]  inst;
    logic [4:0]   reg_numj, reg_numk;
    logic [31:0]  vj, vk;
    logic [3:0]   qj, qk;
    logic [255:0] cdb_data;
    logic [7:0]   cdb_valid;
    logic [7:0]   busy_out, valid_bus;
    logic [255:0] data_bus;
    logic [31:0]  RB_index_bus;
    logic [31:0]  c_ptr, c_wdata;
    logic         c_we, c_ack;

    int checks = 0;
    int errors = 0;

    store_rs dut (
        .clk(clk), .reset(reset), .flush_bus(flush_bus), .fu(fu), .RB_index(RB_index),
        .inst(inst), .reg_numj(reg_numj), .reg_numk(reg_numk), .vj(vj), .vk(vk),
        .qj(qj), .qk(qk), .CDB_data_data(cdb_data), .CDB_data_valid(cdb_valid),
        .busy_out(busy_out), .data_bus(data_bus), .valid_bus(valid_bus),
        .RB_index_bus(RB_index_bus), .c_ptr(c_ptr), .c_wdata(c_wdata),
        .c_write_enable(c_we), .c_ack(c_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {6'b0, rs, rt, imm};
    endfunction

    task automatic set_slot(input int s, input logic [31:0] v);
        cdb_data[s*32 +: 32] = v;
        cdb_valid[s]         = 1'b1;
    endtask

    task automatic dispatch(input logic [3:0] rb, input logic [31:0] in,
                            input logic [3:0] tj, input logic [3:0] tk,
                            input logic [31:0] wj, input logic [31:0] wk);
        fu = 3'd1; RB_index = rb; inst = in; qj = tj; qk = tk; vj = wj; vk = wk;
        tick();
        fu = 3'd0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  {31'b0, busy_out[1]},  32'd0);
        chk({tag, "_valid"}, {31'b0, valid_bus[1]}, 32'd0);
        chk({tag, "_tag"},   {28'b0, RB_index_bus[7:4]}, 32'd14);
    endtask

    initial begin
        reset = 1'b1; flush_bus = '0; fu = 3'd0; RB_index = '0; inst = '0;
        vj = '0; vk = '0; qj = 4'd15; qk = 4'd15; cdb_data = '0; cdb_valid = '0; c_ack = 1'b0;
        tick(); tick();
        chk_idle("rst");
        chk("rst_data", data_bus[63:32], 32'd0);
        chk("rst_cwe",  {31'b0, c_we}, 32'd0);
        chk("rst_ptr",  c_ptr, 32'd0);
        chk("rst_wdata", c_wdata, 32'd0);
        chk("rst_regj", {27'b0, reg_numj}, 32'd0);
        reset = 1'b0;
        tick();

        // Both operands ready at issue
        inst = mk(5'd3, 5'd7, 16'h0008);
        #1;
        chk("idle_regj", {27'b0, reg_numj}, 32'd3);
        chk("idle_regk", {27'b0, reg_numk}, 32'd7);
        dispatch(4'd3, mk(5'd3, 5'd7, 16'h0008), 4'd15, 4'd15, 32'h100, 32'hDEAD);
        chk("t1_busy", {31'b0, busy_out[1]}, 32'd1);
        chk("t1_cwe0", {31'b0, c_we}, 32'd0);
        chk("t1_regj_wait", {27'b0, reg_numj}, 32'd0);
        tick();
        chk("t1_cwe1", {31'b0, c_we}, 32'd1);
        chk("t1_ptr", c_ptr, 32'h108);
        chk("t1_wdata", c_wdata, 32'hDEAD);
        c_ack = 1'b1;
        tick();
        c_ack = 1'b0;
        chk("t1_valid", {31'b0, valid_bus[1]}, 32'd1);
        chk("t1_data", data_bus[63:32], 32'hDEAD);
        chk("t1_tag", {28'b0, RB_index_bus[7:4]}, 32'd3);
        chk("t1_cwe_drop", {31'b0, c_we}, 32'd0);
        tick();
        chk_idle("t1_end");

        // Both pending, released by the CDB on different cycles; long ack wait; dispatch while busy
        dispatch(4'd5, mk(5'd1, 5'd2, 16'hFFFC), 4'd2, 4'd5, 32'hBAD, 32'hBAD);
        tick();
        chk("t2_c1", {31'b0, c_we}, 32'd0);
        set_slot(5, 32'h77);
        tick();
        cdb_valid = '0;
        chk("t2_c2", {31'b0, c_we}, 32'd0);
        tick();
        chk("t2_c3", {31'b0, c_we}, 32'd0);
        set_slot(2, 32'h200);
        tick();
        cdb_valid = '0;
        chk("t2_c4", {31'b0, c_we}, 32'd0);
        tick();
        chk("t2_cwe", {31'b0, c_we}, 32'd1);
        chk("t2_ptr", c_ptr, 32'h1FC);
        chk("t2_wdata", c_wdata, 32'h77);
        for (int k = 0; k < 6; k++) begin
            if (k == 2) begin fu = 3'd1; RB_index = 4'd9; end
            tick();
            fu = 3'd0;
            chk("t2_hold_cwe", {31'b0, c_we}, 32'd1);
            chk("t2_hold_ptr", c_ptr, 32'h1FC);
            chk("t2_hold_wdata", c_wdata, 32'h77);
            chk("t2_hold_tag", {28'b0, RB_index_bus[7:4]}, 32'd5);
            chk("t2_hold_valid", {31'b0, valid_bus[1]}, 32'd0);
        end
        c_ack = 1'b1;
        tick();
        c_ack = 1'b0;
        chk("t2_valid", {31'b0, valid_bus[1]}, 32'd1);
        chk("t2_data", data_bus[63:32], 32'h77);
        chk("t2_tag", {28'b0, RB_index_bus[7:4]}, 32'd5);
        tick();
        chk_idle("t2_end");
        tick();
        chk("t2_one_pulse", {31'b0, valid_bus[1]}, 32'd0);

        // Base tag resolved by the CDB in the dispatch cycle itself
        set_slot(4, 32'h40);
        dispatch(4'd2, mk(5'd4, 5'd9, 16'h0010), 4'd4, 4'd15, 32'h999, 32'h55);
        cdb_valid = '0;
        tick();
        chk("t3_cwe", {31'b0, c_we}, 32'd1);
        chk("t3_ptr", c_ptr, 32'h50);
        chk("t3_wdata", c_wdata, 32'h55);
        c_ack = 1'b1;
        tick();
        c_ack = 1'b0;
        chk("t3_valid", {31'b0, valid_bus[1]}, 32'd1);
        chk("t3_tag", {28'b0, RB_index_bus[7:4]}, 32'd2);
        tick();

        // Flush while waiting for operands
        dispatch(4'd6, mk(5'd6, 5'd1, 16'h0000), 4'd6, 4'd15, 32'h0, 32'h11);
        flush_bus[1] = 1'b1;
        tick();
        flush_bus[1] = 1'b0;
        chk_idle("t4_flush");
        set_slot(6, 32'h600);
        tick();
        cdb_valid = '0;
        tick();
        chk("t4_noreq", {31'b0, c_we}, 32'd0);

        // Flush during the write: request held until ack, no ROB report
        dispatch(4'd7, mk(5'd1, 5'd1, 16'h0000), 4'd15, 4'd15, 32'h300, 32'hAB);
        tick();
        chk("t5_cwe", {31'b0, c_we}, 32'd1);
        flush_bus[1] = 1'b1;
        tick();
        flush_bus[1] = 1'b0;
        chk("t5_hold_cwe", {31'b0, c_we}, 32'd1);
        chk("t5_hold_ptr", c_ptr, 32'h300);
        tick();
        chk("t5_hold_cwe2", {31'b0, c_we}, 32'd1);
        c_ack = 1'b1;
        tick();
        c_ack = 1'b0;
        chk("t5_cwe_drop", {31'b0, c_we}, 32'd0);
        chk_idle("t5_end");
        tick();
        chk("t5_no_pulse", {31'b0, valid_bus[1]}, 32'd0);

        // Async reset in the middle of a write
        dispatch(4'd1, mk(5'd1, 5'd1, 16'h0004), 4'd15, 4'd15, 32'h1000, 32'hCAFE);
        tick();
        chk("t6_cwe", {31'b0, c_we}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_cwe", {31'b0, c_we}, 32'd0);
        chk("t6_rst_ptr", c_ptr, 32'd0);
        chk("t6_rst_wdata", c_wdata, 32'd0);
        chk_idle("t6_rst");
        reset = 1'b0;
        tick();
        chk("t6_after_cwe", {31'b0, c_we}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
